// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller.
// Loads a cipher key over a valid/ready handshake, then produces round keys
// 1..NUM_ROUNDS one per CALC/OUT pair on a backpressured output stream.
// A single 4-byte SubWord path is time-shared across all rounds.

module aes_key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_OUT
  } state_e;

  // Byte x lives at bit offset 8*(255-x); for an 8-bit x that is {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  // Multiply by {02} in GF(2^8); steps rcon through 01,02,04,...,80,1b,36.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   cur_key_q, cur_key_d;
  logic [3:0]     round_q, round_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [127:0]   rk_data_q, rk_data_d;
  logic [3:0]     rk_round_q, rk_round_d;
  logic           rk_valid_q, rk_valid_d;
  logic           done_q, done_d;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    rot_w3, sub_w3, t_word;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;

  // Round-key math: the single SubWord path is fed only from w3 of cur_key.
  always_comb begin
    w0       = cur_key_q[127:96];
    w1       = cur_key_q[95:64];
    w2       = cur_key_q[63:32];
    w3       = cur_key_q[31:0];
    rot_w3   = {w3[23:0], w3[31:24]};
    sub_w3   = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
    t_word   = sub_w3 ^ {rcon_q, 24'h000000};
    n0       = w0 ^ t_word;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Next-state and register-update decode for the IDLE/CALC/OUT sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    cur_key_d  = cur_key_q;
    round_d    = round_q;
    rcon_d     = rcon_q;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          cur_key_d = key_in;
          round_d   = 4'd1;
          rcon_d    = 8'h01;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        cur_key_d  = next_key;
        rk_data_d  = next_key;
        rk_round_d = round_q;
        rk_valid_d = 1'b1;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        // Valid drops on every acceptance so the consumer never sees the
        // previous key twice while the next one is being computed.
        if (rk_ready) begin
          rk_valid_d = 1'b0;
          if (round_q == LAST_ROUND) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            round_d = 4'(round_q + 4'd1);
            rcon_d  = xtime(rcon_q);
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_key_q  <= '0;
      round_q    <= '0;
      rcon_q     <= '0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_key_q  <= cur_key_d;
      round_q    <= round_d;
      rcon_q     <= rcon_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  // done coincides with the first IDLE cycle so the next key can load at once.
  assign key_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rk_data   = rk_data_q;
  assign rk_round  = rk_round_q;
  assign rk_valid  = rk_valid_q;
  assign done      = done_q;

endmodule
